sram_fifo: RTL

//  Synchronous FIFO: valid/ready push and pop interfaces, storage in an instance of the shared sram array.

---
 rtl/sram_fifo_pkg.sv | 13 +
 rtl/sram_fifo_if.sv | 30 +++
 rtl/sram_fifo_sram.sv | 53 +++++
 rtl/sram_fifo.sv | 103 ++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// Shared defaults and index helpers for the sram-backed FIFO and its storage array.
package sram_fifo_pkg;

    localparam int unsigned DEF_DEPTH      = 16;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_AF_THRESH  = 12;

    // Circular increment by explicit compare so non-power-of-two depths wrap correctly.
    function automatic int unsigned wrap_inc(int unsigned idx, int unsigned depth);
        return (idx == depth - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sram_fifo_if.sv
// Push/pop valid-ready bundle plus occupancy status for sram_fifo.
interface sram_fifo_if
    import sram_fifo_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  push_valid;
    logic                  push_ready;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop_valid;
    logic                  pop_ready;
    logic [DATA_WIDTH-1:0] pop_data;
    logic [CNT_W-1:0]      count;
    logic                  almost_full;

    modport master (
        output flush, push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data, count, almost_full
    );

    modport slave (
        input  flush, push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data, count, almost_full
    );

endinterface

// File: rtl/sram_fifo_sram.sv
// Generic multi-port storage array: synchronous writes, zero-latency combinational reads.
module sram
    import sram_fifo_pkg::*;
#(
    parameter int SIZE       = DEF_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_PORTS   = 1,
    parameter int WR_PORTS   = 1,
    parameter int RESETABLE  = 0,
    parameter int ADDR_W     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WR_PORTS-1:0]   Wr_En,
    input  logic [ADDR_W-1:0]     write_address [WR_PORTS],
    input  logic [DATA_WIDTH-1:0] data_in       [WR_PORTS],
    input  logic [ADDR_W-1:0]     read_address  [RD_PORTS],
    output logic [DATA_WIDTH-1:0] data_out      [RD_PORTS]
);

    logic [DATA_WIDTH-1:0] mem_q [SIZE];

    generate
        if (RESETABLE != 0) begin : g_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q <= '{default: '0};
                end else begin
                    for (int w = 0; w < WR_PORTS; w++) begin
                        if (Wr_En[w]) mem_q[write_address[w]] <= data_in[w];
                    end
                end
            end
        end else begin : g_norst
            // Data-only storage: contents survive reset, so rst_n is intentionally left unconnected here.
            logic unused_rst_n;
            assign unused_rst_n = rst_n;

            always_ff @(posedge clk) begin
                for (int w = 0; w < WR_PORTS; w++) begin
                    if (Wr_En[w]) mem_q[write_address[w]] <= data_in[w];
                end
            end
        end
    endgenerate

    always_comb begin
        for (int r = 0; r < RD_PORTS; r++) begin
            data_out[r] = mem_q[read_address[r]];
        end
    end

endmodule

// File: rtl/sram_fifo.sv
// First-word-fall-through FIFO; pointers, occupancy and flow control live here, data lives in u_mem.
module sram_fifo
    import sram_fifo_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int AF_THRESH  = DEF_AF_THRESH
) (
    input  logic           clk,
    input  logic           rst_n,
    sram_fifo_if.slave     fifo_if
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic                  push_ready;
    logic                  pop_valid;
    logic                  push_fire;
    logic                  pop_fire;

    logic [PTR_W-1:0]      mem_wr_addr [1];
    logic [PTR_W-1:0]      mem_rd_addr [1];
    logic [DATA_WIDTH-1:0] mem_wr_data [1];
    logic [DATA_WIDTH-1:0] mem_rd_data [1];

    // No write-through when full and no bypass when empty: flow control depends on count only.
    assign push_ready = (count_q != CNT_W'(DEPTH));
    assign pop_valid  = (count_q != '0);

    always_comb begin
        push_fire = fifo_if.push_valid & push_ready & ~fifo_if.flush;
        pop_fire  = pop_valid & fifo_if.pop_ready & ~fifo_if.flush;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (fifo_if.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_fire) wr_ptr_d = PTR_W'(wrap_inc(32'(wr_ptr_q), DEPTH));
            if (pop_fire)  rd_ptr_d = PTR_W'(wrap_inc(32'(rd_ptr_q), DEPTH));
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign mem_wr_addr[0] = wr_ptr_q;
    assign mem_rd_addr[0] = rd_ptr_q;
    assign mem_wr_data[0] = fifo_if.push_data;

    sram #(
        .SIZE       (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RD_PORTS   (1),
        .WR_PORTS   (1),
        .RESETABLE  (0),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk           (clk),
        .rst_n         (rst_n),
        .Wr_En         (push_fire),
        .write_address (mem_wr_addr),
        .data_in       (mem_wr_data),
        .read_address  (mem_rd_addr),
        .data_out      (mem_rd_data)
    );

    assign fifo_if.push_ready  = push_ready;
    assign fifo_if.pop_valid   = pop_valid;
    assign fifo_if.pop_data    = mem_rd_data[0];
    assign fifo_if.count       = count_q;
    assign fifo_if.almost_full = (count_q >= CNT_W'(AF_THRESH));

    a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CNT_W'(DEPTH));
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push_fire && count_q == CNT_W'(DEPTH)));
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_fire && count_q == '0));
    a_ptr_range : assert property (@(posedge clk) disable iff (!rst_n)
        (32'(wr_ptr_q) < DEPTH) && (32'(rd_ptr_q) < DEPTH));

endmodule
